// File: rtl/cprs_pack_pkg.sv
// Shared definitions for the compressed-IQ output packer: header layout,
// FSM state encodings and data FIFO entry layout.
package cprs_pack_pkg;

  localparam int HDR_W         = 38;
  localparam int HDR_SHIFT_LSB = 0;
  localparam int HDR_INFO_LSB  = 5;
  localparam int HDR_TYPE_LSB  = 13;
  localparam int HDR_PRB_LSB   = 17;
  localparam int HDR_SYMB_LSB  = 26;
  localparam int HDR_SLOT_LSB  = 30;
  localparam int HDR_SEL_BIT   = 37;

  // Data FIFO entry: {data, trunc, eop}
  localparam int ENT_EOP   = 0;
  localparam int ENT_TRUNC = 1;
  localparam int ENT_DATA  = 2;

  typedef enum logic [1:0] {
    IN_IDLE = 2'd0,
    IN_PKT  = 2'd1,
    IN_DROP = 2'd2
  } in_state_t;

  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_HDR  = 2'd1,
    O_DAT0 = 2'd2,
    O_DAT1 = 2'd3
  } out_state_t;

  function automatic logic [HDR_W-1:0] make_hdr(
    input logic       sel,
    input logic [4:0] shift,
    input logic [7:0] info,
    input logic [3:0] ch_type,
    input logic [8:0] prb,
    input logic [3:0] symb,
    input logic [6:0] slot
  );
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_SHIFT_LSB +: 5] = shift;
    h[HDR_INFO_LSB  +: 8] = info;
    h[HDR_TYPE_LSB  +: 4] = ch_type;
    h[HDR_PRB_LSB   +: 9] = prb;
    h[HDR_SYMB_LSB  +: 4] = symb;
    h[HDR_SLOT_LSB  +: 7] = slot;
    h[HDR_SEL_BIT]        = sel;
    return h;
  endfunction

endpackage

// File: rtl/cprs_pack_fifo.sv
// Generic show-ahead FIFO: dout always shows the head entry while !empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  input  logic         rd_en,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_wr, do_rd;

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;
  assign empty = (wr_ptr == rd_ptr);
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cprs_pack.sv
// Packs one 16-channel compressed IQ word per input beat into a header beat
// plus two 8-channel data beats; overflow truncates the packet cleanly.
module cprs_pack
  import cprs_pack_pkg::*;
#(
  parameter int OW         = 16,
  parameter int DATA_DEPTH = 64,
  parameter int HDR_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_sel,
  input  logic                  i_sop,
  input  logic                  i_eop,
  input  logic                  i_vld,
  input  logic [15:0][OW-1:0]   i_din_re,
  input  logic [15:0][OW-1:0]   i_din_im,
  input  logic [4:0]            i_shift,
  input  logic [6:0]            i_slot_idx,
  input  logic [3:0]            i_symb_idx,
  input  logic [8:0]            i_prb_idx,
  input  logic [3:0]            i_ch_type,
  input  logic [7:0]            i_info,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic [16*OW-1:0]      o_tdata,
  output logic                  o_tlast,
  output logic [1:0]            o_tuser,
  output logic                  o_overflow,
  output logic                  o_proto_err,
  output logic [15:0]           o_drop_cnt,
  output logic [1:0]            dbg_in_state,
  output logic [1:0]            dbg_out_state
);

  localparam int DW = 32 * OW;
  localparam int EW = DW + ENT_DATA;
  localparam int BW = 16 * OW;

  in_state_t  in_state, in_next;
  out_state_t out_state, out_next;

  logic [DW-1:0]    din_word, stg_data;
  logic             stg_vld, stg_eop, stg_trunc;
  logic             hdr_push, hdr_pop, hdr_full, hdr_empty;
  logic [HDR_W-1:0] hdr_din, hdr_dout;
  logic             dat_push, dat_pop, dat_full, dat_empty;
  logic [EW-1:0]    dat_din, dat_dout;

  logic new_pkt, cont_beat, stray_beat, skip_beat, missing_eop;
  logic stg_term, eff_eop, eff_trunc, stg_push;
  logic sop_ok, sop_drop, cont_ok, cont_drop, beat_drop;

  assign dbg_in_state  = in_state;
  assign dbg_out_state = out_state;

  always_comb begin
    din_word = '0;
    for (int c = 0; c < 16; c++) din_word[c*2*OW +: 2*OW] = {i_din_im[c], i_din_re[c]};
  end

  // A sop is always judged by idle rules; inside a packet it first closes stg.
  assign new_pkt     = i_vld & i_sop;
  assign cont_beat   = i_vld & ~i_sop & (in_state == IN_PKT);
  assign stray_beat  = i_vld & ~i_sop & (in_state == IN_IDLE);
  assign skip_beat   = i_vld & ~i_sop & (in_state == IN_DROP);
  assign missing_eop = new_pkt & (in_state == IN_PKT);
  assign stg_term    = missing_eop | (cont_beat & dat_full);
  assign eff_eop     = stg_eop | stg_term;
  assign eff_trunc   = stg_trunc | stg_term;
  assign stg_push    = stg_vld & ~dat_full & (eff_eop | cont_beat);
  assign sop_ok      = new_pkt & ~hdr_full & (~stg_vld | stg_push);
  assign sop_drop    = new_pkt & ~sop_ok;
  assign cont_ok     = cont_beat & ~dat_full;
  assign cont_drop   = cont_beat & dat_full;
  assign beat_drop   = sop_drop | cont_drop | stray_beat | skip_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_state <= IN_IDLE;
    else     in_state <= in_next;
  end

  always_comb begin
    in_next = in_state;
    if (sop_ok || cont_ok)         in_next = i_eop ? IN_IDLE : IN_PKT;
    else if (sop_drop || cont_drop) in_next = i_eop ? IN_IDLE : IN_DROP;
    else if (skip_beat && i_eop)   in_next = IN_IDLE;
  end

  always_comb begin
    hdr_push = sop_ok;
    hdr_din  = make_hdr(i_sel, i_shift, i_info, i_ch_type, i_prb_idx, i_symb_idx, i_slot_idx);
    dat_push = stg_push;
    dat_din  = '0;
    dat_din[ENT_EOP]       = eff_eop;
    dat_din[ENT_TRUNC]     = eff_trunc;
    dat_din[ENT_DATA +: DW] = stg_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld   <= 1'b0;
      stg_eop   <= 1'b0;
      stg_trunc <= 1'b0;
      stg_data  <= '0;
    end else if (sop_ok || cont_ok) begin
      stg_vld   <= 1'b1;
      stg_eop   <= i_eop;
      stg_trunc <= 1'b0;
      stg_data  <= din_word;
    end else if (stg_push) begin
      stg_vld   <= 1'b0;
      stg_eop   <= 1'b0;
      stg_trunc <= 1'b0;
    end else if (stg_term) begin
      stg_eop   <= 1'b1;
      stg_trunc <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_overflow  <= 1'b0;
      o_proto_err <= 1'b0;
      o_drop_cnt  <= '0;
    end else begin
      if (sop_drop || cont_drop)                o_overflow  <= 1'b1;
      if (stray_beat || missing_eop)            o_proto_err <= 1'b1;
      if (beat_drop && (o_drop_cnt != 16'hFFFF)) o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

  sync_fifo #(.W(EW), .DEPTH(DATA_DEPTH)) u_dat_fifo (
    .clk(clk), .rst(rst), .wr_en(dat_push), .din(dat_din), .rd_en(dat_pop),
    .dout(dat_dout), .full(dat_full), .empty(dat_empty)
  );

  sync_fifo #(.W(HDR_W), .DEPTH(HDR_DEPTH)) u_hdr_fifo (
    .clk(clk), .rst(rst), .wr_en(hdr_push), .din(hdr_din), .rd_en(hdr_pop),
    .dout(hdr_dout), .full(hdr_full), .empty(hdr_empty)
  );

  // Output handshake: a beat transfers on a cycle with o_tvalid & i_tready; once
  // o_tvalid rises, it and o_tdata/o_tlast/o_tuser hold until that transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_state <= O_IDLE;
    else     out_state <= out_next;
  end

  always_comb begin
    out_next = out_state;
    case (out_state)
      O_IDLE: if (!hdr_empty) out_next = O_HDR;
      O_HDR:  if (i_tready) out_next = O_DAT0;
      O_DAT0: if (!dat_empty && i_tready) out_next = O_DAT1;
      O_DAT1: if (i_tready) begin
        if (!dat_dout[ENT_EOP]) out_next = O_DAT0;
        else                    out_next = hdr_empty ? O_IDLE : O_HDR;
      end
      default: out_next = O_IDLE;
    endcase
  end

  always_comb begin
    o_tvalid = 1'b0;
    o_tdata  = '0;
    o_tlast  = 1'b0;
    o_tuser  = '0;
    hdr_pop  = 1'b0;
    dat_pop  = 1'b0;
    case (out_state)
      O_HDR: begin
        o_tvalid             = 1'b1;
        o_tdata[HDR_W-1:0]   = hdr_dout;
        o_tuser[0]           = 1'b1;
        hdr_pop              = i_tready;
      end
      O_DAT0: begin
        o_tvalid = ~dat_empty;
        if (!dat_empty) o_tdata = dat_dout[ENT_DATA +: BW];
      end
      O_DAT1: begin
        o_tvalid   = 1'b1;
        o_tdata    = dat_dout[ENT_DATA+BW +: BW];
        o_tlast    = dat_dout[ENT_EOP];
        o_tuser[1] = dat_dout[ENT_EOP] & dat_dout[ENT_TRUNC];
        dat_pop    = i_tready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cprs_pack.sv
// Directed bench for cprs_pack: scoreboard of expected output beats checked
// at every negedge, plus status/latency checks after each scenario.
module tb_cprs_pack;

  localparam int OW = 16;
  localparam int BW = 16 * OW;
  localparam int SW = BW + 3;   // {tuser[1:0], tlast, tdata}

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                i_sel = 0, i_sop = 0, i_eop = 0, i_vld = 0;
  logic [15:0][OW-1:0] i_din_re = '0, i_din_im = '0;
  logic [4:0]          i_shift = '0;
  logic [6:0]          i_slot_idx = '0;
  logic [3:0]          i_symb_idx = '0;
  logic [8:0]          i_prb_idx = '0;
  logic [3:0]          i_ch_type = '0;
  logic [7:0]          i_info = '0;
  logic                i_tready = 1'b1;
  logic                o_tvalid, o_tlast, o_overflow, o_proto_err;
  logic [BW-1:0]       o_tdata;
  logic [1:0]          o_tuser, dbg_in_state, dbg_out_state;
  logic [15:0]         o_drop_cnt;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [SW-1:0] exp_q[$];
  bit            bp_en  = 1'b0;
  bit            mon_en = 1'b0;

  always #5 clk = ~clk;

  cprs_pack #(.OW(OW), .DATA_DEPTH(4), .HDR_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .i_sel(i_sel), .i_sop(i_sop), .i_eop(i_eop), .i_vld(i_vld),
    .i_din_re(i_din_re), .i_din_im(i_din_im),
    .i_shift(i_shift), .i_slot_idx(i_slot_idx), .i_symb_idx(i_symb_idx),
    .i_prb_idx(i_prb_idx), .i_ch_type(i_ch_type), .i_info(i_info),
    .o_tvalid(o_tvalid), .i_tready(i_tready), .o_tdata(o_tdata),
    .o_tlast(o_tlast), .o_tuser(o_tuser),
    .o_overflow(o_overflow), .o_proto_err(o_proto_err), .o_drop_cnt(o_drop_cnt),
    .dbg_in_state(dbg_in_state), .dbg_out_state(dbg_out_state)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] re_of(input int w, input int c);
    return {w[7:0], c[3:0], 4'h5};
  endfunction

  function automatic logic [15:0] im_of(input int w, input int c);
    return {w[7:0], c[3:0], 4'hA};
  endfunction

  function automatic logic [37:0] hdr_of(input logic sel, input logic [4:0] shift,
      input logic [6:0] slot, input logic [3:0] symb, input logic [8:0] prb,
      input logic [3:0] ctype, input logic [7:0] info);
    return {sel, slot, symb, prb, ctype, info, shift};
  endfunction

  task automatic exp_hdr(input logic [37:0] h);
    logic [SW-1:0] b;
    b = '0;
    b[37:0] = h;
    b[BW+1] = 1'b1;
    exp_q.push_back(b);
  endtask

  task automatic exp_word(input int w, input bit last, input bit trunc);
    logic [SW-1:0] b0, b1;
    b0 = '0;
    b1 = '0;
    for (int k = 0; k < 8; k++) begin
      b0[k*32 +: 32] = {im_of(w, k), re_of(w, k)};
      b1[k*32 +: 32] = {im_of(w, k + 8), re_of(w, k + 8)};
    end
    b1[BW]   = last;
    b1[BW+2] = trunc;
    exp_q.push_back(b0);
    exp_q.push_back(b1);
  endtask

  task automatic set_meta(input logic sel, input logic [4:0] shift, input logic [6:0] slot,
      input logic [3:0] symb, input logic [8:0] prb, input logic [3:0] ctype, input logic [7:0] info);
    i_sel = sel; i_shift = shift; i_slot_idx = slot; i_symb_idx = symb;
    i_prb_idx = prb; i_ch_type = ctype; i_info = info;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_en) i_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_word(input bit sop, input bit eop, input int w);
    i_vld = 1'b1; i_sop = sop; i_eop = eop;
    for (int c = 0; c < 16; c++) begin
      i_din_re[c] = re_of(w, c);
      i_din_im[c] = im_of(w, c);
    end
  endtask

  task automatic send_beat(input bit sop, input bit eop, input int w);
    drive_word(sop, eop, w);
    tick();
    i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
  endtask

  task automatic send_pkt(input int n, input int base);
    for (int i = 0; i < n; i++) send_beat(i == 0, i == n - 1, base + i);
  endtask

  task automatic drain(input int budget);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      tick();
      cyc++;
    end
    repeat (4) tick();
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", {o_tvalid, o_tlast, o_tuser, o_overflow, o_proto_err, o_drop_cnt}, 0);
    check("rst_tdata", o_tdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard: the presented beat must equal the queue head, while held and on transfer.
  always @(negedge clk) begin
    if (mon_en && !rst && o_tvalid) begin
      if (exp_q.size() == 0) begin
        if (i_tready) check("unexpected_beat", 1, 0);
      end else begin
        check(i_tready ? "beat" : "hold", {o_tuser, o_tlast, o_tdata}, exp_q[0]);
        if (i_tready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    do_reset();
    mon_en = 1'b1;

    // Normal 3-word packet, header value computed by hand.
    i_tready = 1'b1;
    set_meta(1'b1, 5'd7, 7'd5, 4'hC, 9'h1FF, 4'd3, 8'hA5);
    exp_hdr(38'h21_73FE_74A7);
    for (int w = 0; w < 3; w++) exp_word(w, w == 2, 1'b0);
    send_pkt(3, 0);
    drain(100);
    check("norm_drop", o_drop_cnt, 0);
    check("norm_flags", {o_overflow, o_proto_err}, 0);

    // Same packet under random backpressure.
    do_reset();
    exp_hdr(38'h21_73FE_74A7);
    for (int w = 0; w < 3; w++) exp_word(w, w == 2, 1'b0);
    bp_en = 1'b1;
    send_pkt(3, 0);
    drain(300);
    bp_en = 1'b0;
    i_tready = 1'b1;
    check("bp_drop", o_drop_cnt, 0);

    // Data overflow: 4-deep FIFO plus stg keep 5 of 8 words.
    do_reset();
    i_tready = 1'b0;
    set_meta(1'b1, 5'd2, 7'd9, 4'h1, 9'h010, 4'd1, 8'h00);
    exp_hdr(hdr_of(1'b1, 5'd2, 7'd9, 4'h1, 9'h010, 4'd1, 8'h00));
    for (int w = 0; w < 5; w++) exp_word(32 + w, w == 4, w == 4);
    send_pkt(8, 32);
    repeat (3) tick();
    check("ovf_drop", o_drop_cnt, 3);
    check("ovf_flag", o_overflow, 1);
    check("ovf_perr", o_proto_err, 0);
    i_tready = 1'b1;
    drain(200);

    // Header overflow: fifth single-word packet is dropped.
    do_reset();
    i_tready = 1'b0;
    for (int p = 0; p < 5; p++) begin
      set_meta(p[0], 5'(p), 7'(p + 40), 4'(p), 9'(p * 3), 4'(p), 8'(p + 1));
      if (p < 4) begin
        exp_hdr(hdr_of(p[0], 5'(p), 7'(p + 40), 4'(p), 9'(p * 3), 4'(p), 8'(p + 1)));
        exp_word(48 + p, 1'b1, 1'b0);
      end
      send_beat(1'b1, 1'b1, 48 + p);
    end
    repeat (2) tick();
    check("hovf_drop", o_drop_cnt, 1);
    check("hovf_flag", o_overflow, 1);
    check("hovf_perr", o_proto_err, 0);
    i_tready = 1'b1;
    drain(200);

    // Missing eop: second sop truncates the first packet.
    do_reset();
    i_tready = 1'b1;
    set_meta(1'b0, 5'd11, 7'd64, 4'h2, 9'h100, 4'd5, 8'h5A);
    exp_hdr(hdr_of(1'b0, 5'd11, 7'd64, 4'h2, 9'h100, 4'd5, 8'h5A));
    exp_word(64, 1'b0, 1'b0);
    exp_word(65, 1'b1, 1'b1);
    send_beat(1'b1, 1'b0, 64);
    send_beat(1'b0, 1'b0, 65);
    set_meta(1'b1, 5'd31, 7'd127, 4'hF, 9'h001, 4'd15, 8'hFF);
    exp_hdr(hdr_of(1'b1, 5'd31, 7'd127, 4'hF, 9'h001, 4'd15, 8'hFF));
    exp_word(66, 1'b1, 1'b0);
    send_beat(1'b1, 1'b1, 66);
    drain(200);
    check("meop_perr", o_proto_err, 1);
    check("meop_ovf", o_overflow, 0);
    check("meop_drop", o_drop_cnt, 0);

    // Stray beat in idle, then reset in the middle of a packet.
    do_reset();
    i_tready = 1'b0;
    send_beat(1'b0, 1'b0, 80);
    @(negedge clk);
    check("stray_drop", o_drop_cnt, 1);
    check("stray_perr", o_proto_err, 1);
    check("stray_ovf", o_overflow, 0);
    check("stray_tvalid", o_tvalid, 0);
    @(posedge clk);
    #1;
    set_meta(1'b1, 5'd3, 7'd1, 4'h4, 9'h022, 4'd2, 8'h11);
    send_beat(1'b1, 1'b0, 81);
    send_beat(1'b0, 1'b0, 82);
    tick();
    @(negedge clk);
    check("pre_rst_tvalid", o_tvalid, 1);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_ctl", {o_tvalid, o_tlast, o_tuser, o_overflow, o_proto_err, o_drop_cnt}, 0);
    check("mid_rst_tdata", o_tdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_tready = 1'b1;

    // Fresh single-word packet: header at T+2, first data beat at T+3.
    set_meta(1'b0, 5'd9, 7'd77, 4'h6, 9'h0F0, 4'd7, 8'h42);
    exp_hdr(hdr_of(1'b0, 5'd9, 7'd77, 4'h6, 9'h0F0, 4'd7, 8'h42));
    exp_word(90, 1'b1, 1'b0);
    drive_word(1'b1, 1'b1, 90);
    @(posedge clk);
    #1;
    i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    @(negedge clk);
    check("lat_t1", o_tvalid, 0);
    @(negedge clk);
    check("lat_hdr", {o_tvalid, o_tuser[0]}, 2'b11);
    @(negedge clk);
    check("lat_dat0", {o_tvalid, o_tuser[0]}, 2'b10);
    @(posedge clk);
    #1;
    drain(50);
    check("post_rst_drop", o_drop_cnt, 0);
    check("post_rst_flags", {o_overflow, o_proto_err}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
